multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning), one per line:
- OPC_LW, 6'b100011, load word.
- OPC_SW, 6'b101011, store word.
- OPC_BEQ, 6'b000100, branch if equal.
- OPC_ORI, 6'b001101, or-immediate.
- OPC_JRSAL, 6'b010001, jump to rs and link to $31.
- OPC_BALN, 6'b011001, branch-and-link if status N is set.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- in, in, 6, opcode, IR[31:26].
- zero, in, 1, ALU zero flag.
- statusn, in, 1, registered N status flag.
- mem_ready, in, 1, memory access completes this cycle.
- pcwrite, out, 1, unconditional PC load.
- pcwritecond, out, 1, conditional PC load, gated internally.
- iord, out, 1, 0 = PC address, 1 = ALUOut address.
- memread, out, 1, memory read request.
- memwrite, out, 1, memory write request.
- irwrite, out, 1, IR load.
- memtoreg, out, 2, write-back select: 00 ALUOut, 01 MDR, 10 PC.
- regdest, out, 2, destination select: 00 rt, 01 rd, 10 $31.
- regwrite, out, 1, register file write.
- alusrca, out, 1, 0 = PC, 1 = rs.
- alusrcb, out, 2, 00 rt, 01 const 4, 10 sign-ext immediate, 11 sign-ext immediate shifted left 2.
- aluop, out, 2, 00 add, 01 sub, 10 funct field, 11 or.
- pcsource, out, 2, 00 ALU result, 01 ALUOut, 10 rs.
- illegal, out, 1, one-cycle pulse on an undecoded opcode.
- state, out, 4, current state for debug.

Function
REQ-004 The block SHALL hold the state in a 4-bit register updated on the rising clk edge: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQ=8, ORIEX=9, ORIWB=10, JRSAL=11, BALN=12.
REQ-005 In FETCH the block SHALL assert memread with iord=0, alusrca=0, alusrcb=01 and aluop=00 on every cycle.
- It SHALL assert irwrite and pcwrite (pcsource=00) only in the cycle mem_ready=1.
- It SHALL go to DECODE on mem_ready=1, otherwise stay in FETCH.
REQ-006 In DECODE the block SHALL drive alusrca=0, alusrcb=11 and aluop=00, then branch on in:
- 000000 to RTEX
- OPC_LW or OPC_SW to MEMADR
- OPC_BEQ to BEQ
- OPC_ORI to ORIEX
- OPC_JRSAL to JRSAL
- OPC_BALN to BALN
- any other value: pulse illegal for one cycle and go to FETCH.
REQ-007 MEMADR SHALL drive alusrca=1, alusrcb=10 and aluop=00, then go to MEMRD for OPC_LW or MEMWR for OPC_SW.
REQ-008 MEMRD SHALL assert memread with iord=1 and go to MEMWB on mem_ready=1, otherwise hold.
REQ-009 MEMWR SHALL assert memwrite with iord=1 and go to FETCH on mem_ready=1, otherwise hold, keeping memwrite high while waiting.
REQ-010 MEMWB SHALL assert regwrite with memtoreg=01 and regdest=00, then go to FETCH.
REQ-011 RTEX SHALL drive alusrca=1, alusrcb=00 and aluop=10, then go to RTWB.
REQ-012 RTWB SHALL assert regwrite with memtoreg=00 and regdest=01, then go to FETCH.
REQ-013 BEQ SHALL drive alusrca=1, alusrcb=00, aluop=01, pcsource=01 and pcwritecond=1, then go to FETCH.
- PC loads only when zero=1 (zero is gated internally).
REQ-014 ORIEX SHALL drive alusrca=1, alusrcb=10 and aluop=11, then go to ORIWB.
REQ-015 ORIWB SHALL assert regwrite with memtoreg=00 and regdest=00, then go to FETCH.
REQ-016 JRSAL SHALL assert pcwrite with pcsource=10 and regwrite with memtoreg=10 and regdest=10 in the same cycle, then go to FETCH.
- The link value is the already-incremented PC (PC+4).
REQ-017 BALN SHALL drive pcsource=01 and pcwritecond=1, with PC loading only when statusn=1, then go to FETCH.
- regwrite with memtoreg=10 and regdest=10 SHALL be asserted only when statusn=1.
REQ-018 All outputs not listed for a state SHALL be 0.
REQ-019 pcwrite, pcwritecond, memwrite and regwrite SHALL never be asserted in the same cycle as reset=1.
REQ-020 Instruction latencies SHALL be, excluding memory wait cycles: lw 5, sw 4, R-type 4, ori 4, beq/jrsal/baln 3.
REQ-021 The state register SHALL never leave the encodings 0..12; any other value SHALL go to FETCH on the next edge.

Reset
REQ-022 While reset=1 at a rising clk edge, state SHALL become FETCH and illegal SHALL clear, from any state including mid-wait in MEMRD or MEMWR.
REQ-023 In the cycle after reset deasserts, outputs SHALL match the FETCH values of REQ-005.

Verification
REQ-024 Reset, then lw with mem_ready held 1 -> states 0,1,2,3,4,0; regwrite=1, memtoreg=01 only in state 4.
REQ-025 sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then state 0.
REQ-026 beq with zero=0, then beq with zero=1 -> effective PC load only in the second; pcwritecond=1 in both.
REQ-027 baln with statusn=0 -> regwrite=0 in state 12; with statusn=1 -> regwrite=1, regdest=10, memtoreg=10.
REQ-028 Opcode 6'b111111 -> illegal=1 for exactly one cycle in DECODE, then state 0.
REQ-029 reset asserted during a MEMRD wait -> state 0 next edge, no regwrite, memread re-asserted with iord=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a single FSM that sequences fetch, decode,
// execute, memory and write-back, stretching memory states until mem_ready.
module multicycle_control #(
  parameter logic [5:0] OPC_LW    = 6'b100011,
  parameter logic [5:0] OPC_SW    = 6'b101011,
  parameter logic [5:0] OPC_BEQ   = 6'b000100,
  parameter logic [5:0] OPC_ORI   = 6'b001101,
  parameter logic [5:0] OPC_JRSAL = 6'b010001,
  parameter logic [5:0] OPC_BALN  = 6'b011001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] in,
  input  logic       zero,
  input  logic       statusn,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] memtoreg,
  output logic [1:0] regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JRSAL  = 4'd11,
    S_BALN   = 4'd12
  } state_t;

  state_t st, nxt;

  // Architectural write strobes before reset qualification.
  logic pcwrite_c, pcwritecond_c, memwrite_c, regwrite_c;

  always_ff @(posedge clk) begin
    if (reset) st <= S_FETCH;
    else       st <= nxt;
  end

  always_comb begin
    nxt           = S_FETCH;
    pcwrite_c     = 1'b0;
    pcwritecond_c = 1'b0;
    memwrite_c    = 1'b0;
    regwrite_c    = 1'b0;
    iord          = 1'b0;
    memread       = 1'b0;
    irwrite       = 1'b0;
    memtoreg      = 2'b00;
    regdest       = 2'b00;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    aluop         = 2'b00;
    pcsource      = 2'b00;
    illegal       = 1'b0;
    case (st)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite   = 1'b1;
          pcwrite_c = 1'b1;
          nxt       = S_DECODE;
        end else begin
          nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is precomputed here into ALUOut.
        alusrcb = 2'b11;
        if (in == 6'b000000)                  nxt = S_RTEX;
        else if (in == OPC_LW || in == OPC_SW) nxt = S_MEMADR;
        else if (in == OPC_BEQ)               nxt = S_BEQ;
        else if (in == OPC_ORI)               nxt = S_ORIEX;
        else if (in == OPC_JRSAL)             nxt = S_JRSAL;
        else if (in == OPC_BALN)              nxt = S_BALN;
        else begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt     = (in == OPC_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite_c = 1'b1;
        memtoreg   = 2'b01;
      end
      S_MEMWR: begin
        memwrite_c = 1'b1;
        iord       = 1'b1;
        nxt        = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        nxt     = S_RTWB;
      end
      S_RTWB: begin
        regwrite_c = 1'b1;
        regdest    = 2'b01;
      end
      S_BEQ: begin
        alusrca       = 1'b1;
        aluop         = 2'b01;
        pcsource      = 2'b01;
        pcwritecond_c = 1'b1;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = 2'b11;
        nxt     = S_ORIWB;
      end
      S_ORIWB: begin
        regwrite_c = 1'b1;
      end
      S_JRSAL: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        pcwrite_c  = 1'b1;
        pcsource   = 2'b10;
        regwrite_c = 1'b1;
        memtoreg   = 2'b10;
        regdest    = 2'b10;
      end
      S_BALN: begin
        pcsource      = 2'b01;
        pcwritecond_c = 1'b1;
        if (statusn) begin
          regwrite_c = 1'b1;
          memtoreg   = 2'b10;
          regdest    = 2'b10;
        end
      end
      default: nxt = S_FETCH;
    endcase
  end

  // No architectural state may change in a cycle that is being reset.
  assign pcwrite     = pcwrite_c     & ~reset;
  assign pcwritecond = pcwritecond_c & ~reset;
  assign memwrite    = memwrite_c    & ~reset;
  assign regwrite    = regwrite_c    & ~reset;
  assign state       = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a driver pushes hand-computed output
// vectors per cycle, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] in;
  logic       zero, statusn, mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic [1:0] memtoreg, regdest;
  logic       regwrite, alusrca;
  logic [1:0] alusrcb, aluop, pcsource;
  logic       illegal;
  logic [3:0] state;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
  localparam logic [5:0] ORI = 6'b001101, JRSAL = 6'b010001, BALN = 6'b011001;
  localparam logic [5:0] RTYPE = 6'b000000, BAD = 6'b111111;

  multicycle_control dut (
    .clk(clk), .reset(reset), .in(in), .zero(zero), .statusn(statusn),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond),
    .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdest(regdest), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Vector layout: pcwrite pcwritecond iord memread memwrite irwrite memtoreg[2]
  // regdest[2] regwrite alusrca alusrcb[2] aluop[2] pcsource[2] illegal pc_load state[4]
  function automatic logic [23:0] mk(
    input logic pcw, input logic pcwc, input logic io, input logic mr,
    input logic mw, input logic irw, input logic [1:0] mtr, input logic [1:0] rd,
    input logic rw, input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic [1:0] pcs, input logic ill, input logic pl, input logic [3:0] st);
    return {pcw, pcwc, io, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs, ill, pl, st};
  endfunction

  //                                  pcw pcwc io mr mw irw mtr rd rw asa asb aop pcs ill pl st
  localparam logic [23:0] E_FWAIT  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [23:0] E_FGO    = mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
  localparam logic [23:0] E_DEC    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1);
  localparam logic [23:0] E_DECILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 1);
  localparam logic [23:0] E_MADR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 2);
  localparam logic [23:0] E_MRD    = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
  localparam logic [23:0] E_MWB    = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4);
  localparam logic [23:0] E_MWR    = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
  localparam logic [23:0] E_MWRRST = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
  localparam logic [23:0] E_RTEX   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 6);
  localparam logic [23:0] E_RTWB   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 7);
  localparam logic [23:0] E_BEQ0   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 8);
  localparam logic [23:0] E_BEQ1   = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 8);
  localparam logic [23:0] E_ORIEX  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 9);
  localparam logic [23:0] E_ORIWB  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 10);
  localparam logic [23:0] E_JRSAL  = mk(1, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 2, 0, 1, 11);
  localparam logic [23:0] E_BALN0  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 12);
  localparam logic [23:0] E_BALN1  = mk(0, 1, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 1, 0, 1, 12);

  logic [23:0] exp_q[$];
  string       name_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  // Drive one cycle's inputs just after the edge and queue what that cycle must show.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic z, input logic sn, input logic mr, input logic [23:0] e);
    @(posedge clk);
    #1;
    reset = rst; in = op; zero = z; statusn = sn; mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  // Monitor: PC load is derived the way the datapath qualifies pcwritecond.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e, a;
      string nm;
      logic pl;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      pl = pcwrite | (pcwritecond & ((state == 4'd12) ? statusn : zero));
      a  = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdest,
            regwrite, alusrca, alusrcb, aluop, pcsource, illegal, pl, state};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got %06h expected %06h", nm, a, e);
      end
    end
  end

  initial begin
    reset = 1'b1; in = 6'd0; zero = 1'b0; statusn = 1'b0; mem_ready = 1'b0;
    step("reset",        1, RTYPE, 0, 0, 0, E_FWAIT);
    step("post_reset",   0, LW,    0, 0, 0, E_FWAIT);
    // lw, memory always ready
    step("lw_fetch",     0, LW,    0, 0, 1, E_FGO);
    step("lw_decode",    0, LW,    0, 0, 1, E_DEC);
    step("lw_memadr",    0, LW,    0, 0, 1, E_MADR);
    step("lw_memrd",     0, LW,    0, 0, 1, E_MRD);
    step("lw_memwb",     0, LW,    0, 0, 1, E_MWB);
    // sw with three wait cycles
    step("sw_fetch",     0, SW,    0, 0, 1, E_FGO);
    step("sw_decode",    0, SW,    0, 0, 0, E_DEC);
    step("sw_memadr",    0, SW,    0, 0, 0, E_MADR);
    for (int i = 0; i < 3; i++) step("sw_memwr_wait", 0, SW, 0, 0, 0, E_MWR);
    step("sw_memwr_go",  0, SW,    0, 0, 1, E_MWR);
    step("sw_back",      0, BEQ,   0, 0, 0, E_FWAIT);
    // beq not taken then taken
    step("beq0_fetch",   0, BEQ,   0, 0, 1, E_FGO);
    step("beq0_decode",  0, BEQ,   0, 0, 1, E_DEC);
    step("beq0_exec",    0, BEQ,   0, 0, 1, E_BEQ0);
    step("beq1_fetch",   0, BEQ,   1, 0, 1, E_FGO);
    step("beq1_decode",  0, BEQ,   1, 0, 1, E_DEC);
    step("beq1_exec",    0, BEQ,   1, 0, 1, E_BEQ1);
    // R-type and ori
    step("rt_fetch",     0, RTYPE, 0, 0, 1, E_FGO);
    step("rt_decode",    0, RTYPE, 0, 0, 1, E_DEC);
    step("rt_ex",        0, RTYPE, 0, 0, 1, E_RTEX);
    step("rt_wb",        0, RTYPE, 0, 0, 1, E_RTWB);
    step("ori_fetch",    0, ORI,   0, 0, 1, E_FGO);
    step("ori_decode",   0, ORI,   0, 0, 1, E_DEC);
    step("ori_ex",       0, ORI,   0, 0, 1, E_ORIEX);
    step("ori_wb",       0, ORI,   0, 0, 1, E_ORIWB);
    // jrsal, then baln with N clear and set
    step("jrsal_fetch",  0, JRSAL, 0, 0, 1, E_FGO);
    step("jrsal_decode", 0, JRSAL, 0, 0, 1, E_DEC);
    step("jrsal_exec",   0, JRSAL, 0, 0, 1, E_JRSAL);
    step("baln0_fetch",  0, BALN,  1, 0, 1, E_FGO);
    step("baln0_decode", 0, BALN,  1, 0, 1, E_DEC);
    step("baln0_exec",   0, BALN,  1, 0, 1, E_BALN0);
    step("baln1_fetch",  0, BALN,  0, 1, 1, E_FGO);
    step("baln1_decode", 0, BALN,  0, 1, 1, E_DEC);
    step("baln1_exec",   0, BALN,  0, 1, 1, E_BALN1);
    // undecoded opcode
    step("ill_fetch",    0, BAD,   0, 0, 1, E_FGO);
    step("ill_decode",   0, BAD,   0, 0, 0, E_DECILL);
    step("ill_back",     0, BAD,   0, 0, 0, E_FWAIT);
    // reset in the middle of a MEMRD wait
    step("rrd_fetch",    0, LW,    0, 0, 1, E_FGO);
    step("rrd_decode",   0, LW,    0, 0, 0, E_DEC);
    step("rrd_memadr",   0, LW,    0, 0, 0, E_MADR);
    step("rrd_wait",     0, LW,    0, 0, 0, E_MRD);
    step("rrd_reset",    1, LW,    0, 0, 0, E_MRD);
    step("rrd_fetch2",   0, LW,    0, 0, 0, E_FWAIT);
    // reset in the middle of a MEMWR wait must suppress memwrite
    step("rwr_fetch",    0, SW,    0, 0, 1, E_FGO);
    step("rwr_decode",   0, SW,    0, 0, 0, E_DEC);
    step("rwr_memadr",   0, SW,    0, 0, 0, E_MADR);
    step("rwr_wait",     0, SW,    0, 0, 0, E_MWR);
    step("rwr_reset",    1, SW,    0, 0, 0, E_MWRRST);
    step("rwr_fetch2",   0, SW,    0, 0, 0, E_FWAIT);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
